// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: register file access bundle; master drives requests, slave answers
interface reg_file_mp_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
);
    logic                 clrReq;
    logic                 ready;
    logic                 regWen;
    logic [AW-1:0]        writeReg;
    logic [XLEN-1:0]      writeData;
    logic [NRD*AW-1:0]    readAddr;
    logic [NRD*XLEN-1:0]  readData;
    logic                 writeDrop;

    modport master (
        output clrReq, regWen, writeReg, writeData, readAddr,
        input  ready, readData, writeDrop
    );

    modport slave (
        input  clrReq, regWen, writeReg, writeData, readAddr,
        output ready, readData, writeDrop
    );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port register file, x0 hardwired, one-entry-per-cycle clear sweep.
// Define RF_BYPASS_EN to forward a same-cycle write onto matching read ports.
module reg_file_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
) (
    input logic          Clk,
    input logic          Rst,
    reg_file_mp_if.slave bus
);
    typedef enum logic {CLEAR, READY} state_t;

    localparam logic [31:0] NR = NREG;

    state_t          state, state_n;
    logic [AW-1:0]   clr_idx, idx_n;
    logic [XLEN-1:0] mem [2**AW];
    logic            last, wr_ok, drop_n, drop_q, hit;
    logic [AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;

    always_comb begin
        last    = 32'(clr_idx) == NR - 1;
        wr_ok   = bus.regWen && state == READY && bus.writeReg != '0 && 32'(bus.writeReg) < NR;
        drop_n  = bus.regWen && (state != READY || 32'(bus.writeReg) >= NR);
        state_n = state == CLEAR ? (last ? READY : CLEAR) : (bus.clrReq ? CLEAR : READY);
        idx_n   = (state == CLEAR && !last) ? clr_idx + AW'(1) : '0;
    end

    // Reset parks the sequencer at the start of a sweep so the first edge after release clears entry 0
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
            drop_q  <= 1'b0;
        end else begin
            state   <= state_n;
            clr_idx <= idx_n;
            drop_q  <= drop_n;
        end
    end

    always_ff @(posedge Clk) begin
        if (state == CLEAR)
            mem[clr_idx] <= '0;
        else if (wr_ok)
            mem[bus.writeReg] <= bus.writeData;
    end

    always_comb begin
        rd  = '0;
        ra  = '0;
        hit = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            ra  = bus.readAddr[i*AW +: AW];
            hit = state == READY && ra != '0 && 32'(ra) < NR;
`ifdef RF_BYPASS_EN
            rd[i*XLEN +: XLEN] = !hit ? '0 : (wr_ok && bus.writeReg == ra) ? bus.writeData : mem[ra];
`else
            rd[i*XLEN +: XLEN] = hit ? mem[ra] : '0;
`endif
        end
    end

    assign bus.ready     = state == READY;
    assign bus.writeDrop = drop_q;
    assign bus.readData  = rd;
endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port integer register file for the RV32I pipeline, the successor to the single-write/dual-read bank used in decode. The pipeline reads it in ID and writes it from WB. It adds configurable width, depth and read-port count, and a hardwired-zero entry 0. A reset/clear sequencer sweeps the array to zero one entry per cycle and holds `ready` low until the sweep is done. Read contents no longer come from a memory init file.

## Interface
Parameters:
- `XLEN`, 32: data width.
- `NREG`, 32: number of entries, 2..2^AW.
- `AW`, 5: register address width.
- `NRD`, 2: number of read ports, 1..4.

Ports:
- `Clk`  in  1  the single clock; all state updates on posedge.
- `Rst`  in  1  reset, asynchronous, active-low.
- `clrReq`  in  1  request a full clear sweep.
- `ready`  out  1  1 = array valid; reads and writes are honoured.
- `regWen`  in  1  write enable.
- `writeReg`  in  AW  write address.
- `writeData`  in  XLEN  write data.
- `readAddr`  in  NRD*AW  packed read addresses; port i is at bits [i*AW +: AW].
- `readData`  out  NRD*XLEN  packed read data; combinational from `readAddr`.
- `writeDrop`  out  1  registered one-cycle pulse; a requested write was discarded.

## Operation
- **States.** RST (`Rst` low), CLEAR, READY.
- **RST.**
  - Entered asynchronously while `Rst`=0.
  - Clear counter `clrIdx`=0, `ready`=0, `writeDrop`=0.
  - Leaves to CLEAR on the first posedge after `Rst` returns to 1.
- **CLEAR.**
  - Each posedge writes 0 to entry `clrIdx`, then increments `clrIdx`.
  - When `clrIdx`=NREG-1 is written, the next state is READY and `clrIdx` returns to 0.
  - `clrReq` is ignored; the sweep is not restarted.
- **READY.**
  - `clrReq`=1 at a posedge moves to CLEAR with `clrIdx`=0.
  - A write presented on that same edge is still committed; the sweep then clears it.
- **Write.**
  - Commits at posedge when `regWen`=1, the state is READY, and 0 < `writeReg` < NREG.
  - `writeReg`=0 is silently ignored (entry 0 is hardwired); `writeDrop` is not raised.
  - `regWen`=1 while not READY, or with `writeReg` >= NREG: the write is discarded and `writeDrop`=1 for the following cycle.
- **Read.**
  - `readData[i]` = entry[`readAddr[i]`].
  - Returns 0 when `readAddr[i]`=0, when `readAddr[i]` >= NREG, or when `ready`=0.
- **Multiple read ports.** The same address on several read ports returns identical data. There are no port conflicts.
- **Reset mid-sweep.** Asserting `Rst` during CLEAR aborts the sweep. The sweep restarts from index 0 after `Rst` is released.

## Timing
- **Reset values.** `ready`=0 and `writeDrop`=0. `readData` reads as 0 because `ready`=0.
- **Sweep duration.** The sweep takes exactly NREG posedges. `ready` rises after the NREG-th posedge following `Rst` release or `clrReq` acceptance (32 cycles at default).
- **Write latency.** A write at posedge N is visible on every read port from N+ (after the edge). Same-cycle visibility depends on the Configuration macro.
- **`writeDrop` timing.** High for exactly one cycle, the cycle after the offending posedge. Back-to-back dropped writes hold it high continuously.
- **`ready` after `clrReq`.** `ready` falls the cycle after `clrReq` is accepted in READY.

## Configuration
- **Macro.** `RF_BYPASS_EN` selects same-cycle write forwarding.
- **Defined.** Write-to-read forwarding is compiled in. When `regWen`=1, the state is READY, `writeReg`!=0, `writeReg` < NREG, and `readAddr[i]`=`writeReg`, `readData[i]`=`writeData` combinationally in the same cycle.
- **Not defined.** `readData[i]` returns the stored (old) value in that cycle; the new value appears after the posedge. The pipeline must then rely on external forwarding.

## Test plan
- **Reset sweep.** Pulse `Rst` low, release, hold `clrReq`=0 -> `ready`=0 for 32 cycles, then 1. All 32 entries read 0.
- **Write/read and x0.**
  - Write 0xDEADBEEF to x5, read x5 on both ports next cycle -> 0xDEADBEEF on both.
  - Write 0x1234 to x0, then read x0 -> 0; `writeDrop` stays 0.
- **Bypass.** Write 0xA5A5A5A5 to x7 while `readAddr[0]`=7 in the same cycle.
  - With `RF_BYPASS_EN` -> `readData[0]`=0xA5A5A5A5 in that cycle.
  - Without it -> the old value in that cycle, 0xA5A5A5A5 the next cycle.
- **Clear request.** In READY, load x1..x31 with index*3, then pulse `clrReq`.
  - `ready` is 0 for 32 cycles.
  - `regWen`=1 to x9 mid-sweep -> `writeDrop`=1 for one cycle and x9 reads 0 after the sweep.
  - A second `clrReq` mid-sweep does not extend the 32-cycle window.
- **Non-power-of-two depth.** With NREG=24, write to x30 -> `writeDrop`=1 and a read of x30 returns 0. The sweep lasts 24 cycles.
- **Reset mid-sweep.** Assert `Rst` during cycle 10 of a sweep, release 3 cycles later -> `ready` rises exactly 32 cycles after release.
